// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the sequential multiplier and the control unit's MUL path.
package mul16_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;

  // Cycles from the accepting start edge to the cycle in which done is high.
  localparam int unsigned MUL_LATENCY = 18;

  // Control-unit opcodes that route through the multiplier.
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_MULU = 4'hB;

  // Product does not fit in 16 bits (signed: upper half is not a sign extension).
  function automatic logic mul_ovf(input logic [31:0] p, input logic sgn);
    if (sgn) return (p[31:16] != {16{p[15]}});
    else     return (p[31:16] != 16'h0000);
  endfunction

endpackage

// File: rtl/mul16_seq_add32.sv
// 32-bit ripple adder shared with the processor datapath.
module add32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_s,
  output logic        o_cout
);

  logic [32:0] w_sum;

  // Single full-width add; carry out taken from bit 32.
  always_comb begin
    w_sum  = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
    o_s    = w_sum[31:0];
    o_cout = w_sum[32];
  end

endmodule

// File: rtl/mul16_seq.sv
// Multi-cycle 16x16 -> 32 shift-and-add multiplier. Operands are reduced to
// magnitudes on start, accumulated over 16 cycles through the shared adder,
// and the sign is applied in one extra FIX cycle through the same adder.
module mul16_seq
  import mul16_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  mul_state_t r_state, w_next;

  logic               r_sgn;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_add_a;
  logic [2*WIDTH-1:0] w_add_b;
  logic               w_add_cin;
  logic [2*WIDTH-1:0] w_sum;
  logic               w_unused_cout;

  // Operand magnitudes; 0x8000 negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    w_a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    w_b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // Adder operand mux: accumulate in CALC, conditional two's-complement in FIX.
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    case (r_state)
      ST_CALC: begin
        w_add_a = r_acc;
        w_add_b = r_mplr[0] ? r_mcand : '0;
      end
      ST_FIX: begin
        w_add_a   = r_neg ? ~r_acc : r_acc;
        w_add_cin = r_neg;
      end
      default: ;
    endcase
  end

  add32 u_add (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_s    (w_sum),
    .o_cout (w_unused_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_CALC;
      ST_CALC: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) w_next = ST_FIX;
      end
      ST_FIX: begin
        busy   = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, shift-and-add iterations, result commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgn     <= 1'b0;
      r_neg     <= 1'b0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_sgn   <= is_signed;
          r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
          r_mplr  <= w_b_mag;
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        ST_CALC: begin
          r_acc   <= w_sum;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          r_product <= w_sum;
          r_ovf     <= mul_ovf(w_sum, r_sgn);
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq with a scoreboard of expected products.
module tb_mul16_seq;
  import mul16_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] p;
    logic        o;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mul16_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Reference product computed arithmetically, independent of the shift-add structure.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
    exp_t e;
    logic signed [31:0] sx, sy;
    if (s) begin
      sx  = {{16{x[15]}}, x};
      sy  = {{16{y[15]}}, y};
      e.p = 32'(sx * sy);
      e.o = (e.p[31:16] != {16{e.p[15]}});
    end else begin
      e.p = {16'd0, x} * {16'd0, y};
      e.o = (e.p[31:16] != 16'd0);
    end
    return e;
  endfunction

  // One operation: pushes its expectation, pulses start, tracks busy/done timing,
  // then pops and compares. If poke=1 a second start is issued mid-operation.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic s, input exp_t e, input bit poke);
    int   c;
    int   busy_cnt;
    int   lat;
    bit   got;
    exp_t q;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; a = x; b = y; is_signed = s;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y; is_signed = ~s;
    c = 1; busy_cnt = 0; lat = 0; got = 0;
    while (!got && c <= 40) begin
      if (done) begin
        got = 1; lat = c;
      end else begin
        if (busy) busy_cnt++;
        if (poke && c == 5) begin
          start = 1'b1; a = 16'h7777; b = 16'h0123; is_signed = 1'b0;
        end else start = 1'b0;
        @(negedge clk);
        c++;
      end
    end
    // A start during the done cycle must be ignored as well.
    start = 1'b1; a = 16'h0F0F; b = 16'h0F0F;
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(MUL_LATENCY));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd17);
    if (sb_q.size() > 0) begin
      q = sb_q.pop_front();
      check({tag, " product"}, product, q.p);
      check({tag, " ovf"}, 32'(ovf), 32'(q.o));
    end else check({tag, " scoreboard_empty"}, 32'(sb_q.size()), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_pulse_len"}, 32'({done, busy}), 32'd0);
    check({tag, " product_held"}, product, q.p);
  endtask

  initial begin
    int   c;
    bit   saw_done;
    exp_t e;

    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", product, 32'h0);
    check("reset ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    e = '{p: 32'h0000000F, o: 1'b0}; run_op("u3x5",      16'h0003, 16'h0005, 1'b0, e, 1'b0);
    e = '{p: 32'hFFFE0001, o: 1'b1}; run_op("umax",      16'hFFFF, 16'hFFFF, 1'b0, e, 1'b0);
    e = '{p: 32'hFFFFFFEB, o: 1'b0}; run_op("s_m3x7",    16'hFFFD, 16'h0007, 1'b1, e, 1'b0);
    e = '{p: 32'h40000000, o: 1'b1}; run_op("s_min_sq",  16'h8000, 16'h8000, 1'b1, e, 1'b0);
    e = '{p: 32'hFFFF8000, o: 1'b0}; run_op("s_minx1",   16'h8000, 16'h0001, 1'b1, e, 1'b0);
    e = '{p: 32'h00000000, o: 1'b0}; run_op("zero_b",    16'h1234, 16'h0000, 1'b0, e, 1'b0);
    e = '{p: 32'h0000000F, o: 1'b0}; run_op("poke_busy", 16'h0003, 16'h0005, 1'b0, e, 1'b1);
    run_op("s_model",  16'h1234, 16'hF00F, 1'b1, model(16'h1234, 16'hF00F, 1'b1), 1'b0);
    run_op("u_model",  16'h00FF, 16'h0101, 1'b0, model(16'h00FF, 16'h0101, 1'b0), 1'b0);
    run_op("s_neg_sq", 16'hFF00, 16'hFF00, 1'b1, model(16'hFF00, 16'hFF00, 1'b1), 1'b0);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    start = 1'b1; a = 16'h00AA; b = 16'h0055; is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (c = 1; c < 8; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst product", product, 32'h0);
    check("midrst ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("midrst no_activity", 32'(saw_done), 32'd0);

    e = '{p: 32'h00000006, o: 1'b0}; run_op("post_rst", 16'h0002, 16'h0003, 1'b0, e, 1'b0);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Multi-cycle 16x16 -> 32-bit shift-and-add multiplier for the 16-bit single-cycle processor's MUL/MULU path.
- Sits directly upstream of the team's 32-bit adder: every cycle it drives that adder's A/B/carry_in and captures S back into its accumulator.
- Exposes a start/busy/done handshake to the control unit, which stalls the PC while busy.
- Holds the product until the next start.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported because the product must equal the 32-bit adder width.
- CNT_W, 5, iteration counter width. Must hold the value WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request. Sampled only in IDLE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned. Sampled with start.
- a  in  16  multiplicand. Sampled with start.
- b  in  16  multiplier. Sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when product is valid.
- product  out  32  result. Held stable until the next accepted start.
- ovf  out  1  result does not fit in 16 bits. Signed: product[31:16] is not all copies of product[15]. Unsigned: product[31:16] != 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While rst=1 at a rising edge:
  - state goes to IDLE;
  - busy, done and ovf go to 0;
  - product goes to 0x00000000;
  - accumulator, shift registers and counter are cleared.
  - This applies mid-operation too: the partial result is discarded and no done pulse is produced.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start=1, latch is_signed into sgn_r and latch neg_r = is_signed & (a[15]^b[15]).
  - Latch magnitudes: |a| zero-extended to 32 bits into mcand, |b| into mplr (16 bits).
  - Magnitude of 0x8000 is 0x8000 (unsigned 32768).
  - Clear acc and cnt, then go to CALC.
  - start=0: stay in IDLE.
- CALC (exactly 16 cycles):
  - Adder inputs: A=acc, B=(mplr[0] ? mcand : 0), carry_in=0.
  - Each cycle: acc <= S; mcand <= mcand<<1; mplr <= mplr>>1; cnt <= cnt+1.
  - When cnt reaches 15, go to FIX.
  - There is no early-out; latency is fixed.
- FIX (1 cycle):
  - Adder inputs: A=(neg_r ? ~acc : acc), B=0, carry_in=neg_r.
  - product <= S; ovf computed from S and sgn_r. Go to DONE.
  - The adder is the only adder in the datapath; it is shared by CALC and FIX.
- DONE (1 cycle): done=1, busy=0, then go to IDLE. A start in the DONE cycle is ignored.
- busy=1 in CALC and FIX only.
- Latency: start sampled at edge N -> busy high from cycle N+1 -> done high in cycle N+18.
- The adder's carry_out is unused. The 32-bit accumulate cannot overflow, because 0xFFFF*0xFFFF < 2^32.
- start asserted while not in IDLE is ignored and not queued.
- product and ovf change only in FIX or on reset.

Decomposition:
- Shared package (cpu_pkg) holds:
  - mul state encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3;
  - MUL_LATENCY=18;
  - the MUL/MULU opcode constants used by the control unit.
- The only sub-module is the existing 32-bit adder, instantiated once inside mul16_seq.
- Operand magnitude logic and the operand mux stay inline; no further sub-modules.

Test Plan:
- Unsigned 3*5: a=0x0003, b=0x0005, is_signed=0, start pulse.
  - Required: busy=1 for 17 cycles; done in cycle N+18; product=0x0000000F; ovf=0.
- Unsigned max: a=0xFFFF, b=0xFFFF, is_signed=0.
  - Required: product=0xFFFE0001, ovf=1.
- Signed mixed: a=0xFFFD (-3), b=0x0007, is_signed=1.
  - Required: product=0xFFFFFFEB (-21), ovf=0.
- Signed corner: a=0x8000, b=0x8000, is_signed=1.
  - Required: product=0x40000000, ovf=1.
- Signed corner: a=0x8000, b=0x0001, is_signed=1.
  - Required: product=0xFFFF8000, ovf=0.
- Zero operand: b=0x0000, a=0x1234.
  - Required: product=0, ovf=0, latency still 18 cycles.
- Start while busy, then reset:
  - Second start at cycle N+5 with different operands: ignored; first result delivered unchanged.
  - Next run: rst=1 at cycle N+8: next cycle busy=0, done=0, product=0.
  - No done pulse afterwards.
  - A fresh start computing 0x0002*0x0003 completes normally with 0x00000006.
